// File: rtl/switch_debounce4_pkg.sv
// Shared constants for the four-switch debounce stage: channel count, default
// debounce window and the counter width derived from it.
package switch_debounce4_pkg;

  localparam int unsigned NUM_CH              = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  // Smallest counter width with 2**w > n.
  function automatic int unsigned cnt_w_for(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_w_for(DEBOUNCE_CYCLES_DEF);

  typedef logic [NUM_CH-1:0] sw_vec_t;

endpackage

// File: rtl/switch_debounce4_channel.sv
// One switch channel: two-flop synchronizer, persistence counter, debounced
// level and registered one-cycle rise/fall pulses.
module debounce_channel
  import switch_debounce4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Synchronizer runs every clock; counter and stable level advance only on strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_en) begin
        if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt < CNT_LAST) begin
          cnt <= cnt + CNT_W'(1);
        end else begin
          // Level persisted for the full window: accept it and pulse the edge.
          stable <= s2;
          cnt    <= '0;
          rise   <= s2;
          fall   <= ~s2;
        end
      end
    end
  end

endmodule

// File: rtl/switch_debounce4.sv
// Four independent debounced switch channels {A,B,C,D}; feeds logic_func2.inputs
// and flags any accepted level change.
module switch_debounce4
  import switch_debounce4_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [NUM_CH-1:0] sw_raw,
  output logic [NUM_CH-1:0] sw_stable,
  output logic [NUM_CH-1:0] sw_rise,
  output logic [NUM_CH-1:0] sw_fall,
  output logic              any_change
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .raw       (sw_raw[i]),
      .stable    (sw_stable[i]),
      .rise      (sw_rise[i]),
      .fall      (sw_fall[i])
    );
  end

  // OR of registered pulses, so it is high on exactly the pulse cycle.
  assign any_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_debounce4.sv
// Directed self-checking bench for switch_debounce4 with a 4-sample window.
module tb_switch_debounce4;

  localparam int unsigned DC = 4;
  localparam int unsigned CW = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic [3:0] sw_raw;
  logic [3:0] sw_stable;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
  logic       any_change;

  int         nchecks = 0;
  int         nerr    = 0;
  logic [3:0] exp_st  = 4'b0000;

  switch_debounce4 #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [3:0] st,
                             input logic [3:0] ri, input logic [3:0] fa);
    check({tag, ".stable"}, sw_stable, st);
    check({tag, ".rise"}, sw_rise, ri);
    check({tag, ".fall"}, sw_fall, fa);
    check({tag, ".any_change"}, {3'b000, any_change}, {3'b000, |(ri | fa)});
  endtask

  // Apply a clean level; it must appear exactly on the DC+2 edge with one pulse.
  task automatic settle(input string tag, input logic [3:0] new_raw);
    logic [3:0] ri;
    logic [3:0] fa;
    ri = new_raw & ~exp_st;
    fa = ~new_raw & exp_st;
    sw_raw = new_raw;
    for (int k = 0; k < int'(DC) + 1; k++) begin
      tick();
      expect_outs({tag, ".wait"}, exp_st, 4'b0000, 4'b0000);
    end
    tick();
    exp_st = new_raw;
    expect_outs({tag, ".accept"}, exp_st, ri, fa);
    tick();
    expect_outs({tag, ".after"}, exp_st, 4'b0000, 4'b0000);
  endtask

  initial begin
    // Reset with all switches high
    rst_n     = 1'b0;
    sample_en = 1'b1;
    sw_raw    = 4'b1111;
    tick();
    tick();
    expect_outs("reset", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    settle("reset_release", 4'b1111);
    settle("all_low", 4'b0000);

    // Clean presses
    settle("press_a", 4'b1000);
    settle("press_b", 4'b1100);
    settle("release_b", 4'b1000);

    // Bounce on B around its stable low level
    for (int k = 0; k < 6; k++) begin
      sw_raw = (k % 2 == 0) ? 4'b1100 : 4'b1000;
      tick();
      expect_outs("bounce", 4'b1000, 4'b0000, 4'b0000);
    end
    sw_raw = 4'b1000;
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_outs("bounce_settle", 4'b1000, 4'b0000, 4'b0000);
    end

    // Glitch of DC-1 samples on C must be rejected
    sw_raw = 4'b1010;
    for (int k = 0; k < int'(DC) - 1; k++) begin
      tick();
      expect_outs("glitch", 4'b1000, 4'b0000, 4'b0000);
    end
    sw_raw = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_outs("glitch_settle", 4'b1000, 4'b0000, 4'b0000);
    end

    // Strobe every 3rd cycle: acceptance on the 4th strobe after sync (edge 13)
    sw_raw = 4'b1001;
    for (int k = 0; k < 14; k++) begin
      sample_en = (k % 3 == 0);
      tick();
      if (k < 12)       expect_outs("strobe_hold", 4'b1000, 4'b0000, 4'b0000);
      else if (k == 12) expect_outs("strobe_accept", 4'b1001, 4'b0001, 4'b0000);
      else              expect_outs("strobe_after", 4'b1001, 4'b0000, 4'b0000);
    end
    exp_st    = 4'b1001;
    sample_en = 1'b1;

    // Multi-channel simultaneous changes
    settle("multi_clear", 4'b0000);
    settle("multi_rise", 4'b1111);
    settle("multi_fall", 4'b0000);

    // Reset after two qualified samples discards progress
    sw_raw = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_outs("midcount", 4'b0000, 4'b0000, 4'b0000);
    end
    rst_n = 1'b0;
    #1;
    expect_outs("midcount_reset", 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    expect_outs("midcount_reset_hold", 4'b0000, 4'b0000, 4'b0000);
    rst_n  = 1'b1;
    exp_st = 4'b0000;
    settle("midcount_release", 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
